uart_rx: RTL and testbench

Asynchronous serial receiver: the receive-side counterpart of the board's UART transmitter. Recovers 8N1 frames from the PC-facing `rx` pin with mid-bit sampling and presents each byte as a one-cycle valid pulse. Feeds command bytes, such as alarm threshold or display mode, to the control logic that sits alongside the DS18B20 / segment-display / beeper path.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/rx_sync.sv | 31 +++
 rtl/uart_rx.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default line settings, FSM state encoding and
// bit-timing / parity helpers used by both uart_tx and uart_rx.
package uart_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 115_200;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;

  function automatic int calc_bit_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int calc_half(input int clk_freq, input int baud);
    return calc_bit_cnt(clk_freq, baud) / 2;
  endfunction

  // Non-zero when data plus parity bit do not form even parity.
  function automatic logic even_par_err(input logic [7:0] data, input logic par);
    return (^data) ^ par;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin plus a history register
// that flags a falling edge on the synchronised line.
module rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Idle-high reset values so that reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign rx_s = sync2_r;
  assign fall = prev_r & ~sync2_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Mid-bit sampling, one-cycle dout_vld / frame_err / parity_err pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int          BIT_CNT   = calc_bit_cnt(CLK_FREQ, BAUD);
  localparam int          HALF      = calc_half(CLK_FREQ, BAUD);
  localparam logic [15:0] BIT_LAST  = 16'(BIT_CNT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

  logic        rx_s;
  logic        fall_s;
  logic [2:0]  state_r;
  logic [2:0]  state_nx_s;
  logic [15:0] cnt_r;
  logic [2:0]  idx_r;
  logic [7:0]  shift_r;
  logic        half_done_s;
  logic        bit_done_s;
  logic        sample_s;
  logic        shift_en_s;
  logic        par_cap_s;
  logic        good_s;
  logic        ferr_s;
  logic        perr_s;
  logic        par_bad_s;
  logic [7:0]  dout_r;
  logic        dout_vld_r;
  logic        frame_err_r;
  logic        parity_err_r;
  logic        busy_r;

  rx_sync u_rx_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall_s)
  );

  assign half_done_s = (cnt_r == HALF_LAST);
  assign bit_done_s  = (cnt_r == BIT_LAST);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (fall_s) state_nx_s = START;
        else        state_nx_s = IDLE;
      end
      START: begin
        if (half_done_s) state_nx_s = rx_s ? IDLE : DATA;
        else             state_nx_s = START;
      end
      DATA: begin
        if (bit_done_s && (idx_r == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_nx_s = PARITY;
`else
          state_nx_s = STOP;
`endif
        end else begin
          state_nx_s = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_done_s) state_nx_s = STOP;
        else            state_nx_s = PARITY;
      end
`endif
      STOP: begin
        if (bit_done_s) state_nx_s = rx_s ? IDLE : WAIT_HIGH;
        else            state_nx_s = STOP;
      end
      WAIT_HIGH: begin
        if (rx_s) state_nx_s = IDLE;
        else      state_nx_s = WAIT_HIGH;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM output decode: sample strobes and frame verdicts.
  always_comb begin
    sample_s   = 1'b0;
    shift_en_s = 1'b0;
    par_cap_s  = 1'b0;
    good_s     = 1'b0;
    ferr_s     = 1'b0;
    perr_s     = 1'b0;
    case (state_r)
      START: begin
        sample_s = half_done_s;
      end
      DATA: begin
        sample_s   = bit_done_s;
        shift_en_s = bit_done_s;
      end
      PARITY: begin
        sample_s  = bit_done_s;
        par_cap_s = bit_done_s;
      end
      STOP: begin
        sample_s = bit_done_s;
        good_s   = bit_done_s & rx_s & ~par_bad_s;
        perr_s   = bit_done_s & rx_s & par_bad_s;
        ferr_s   = bit_done_s & ~rx_s;
      end
      default: begin
        sample_s = 1'b0;
      end
    endcase
  end

  // Baud counter: restarts on every state change and at each sample point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 16'd0;
    end else if ((state_r == IDLE) || (state_nx_s != state_r) || sample_s) begin
      cnt_r <= 16'd0;
    end else begin
      cnt_r <= cnt_r + 16'd1;
    end
  end

  // Data bit index and LSB-first shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      if (state_r != DATA) idx_r <= 3'd0;
      else if (shift_en_s) idx_r <= idx_r + 3'd1;
      if (shift_en_s) shift_r <= {rx_s, shift_r[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad_r;

  // Parity verdict captured at the parity sample, consumed at the stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad_r <= 1'b0;
    end else if (par_cap_s) begin
      par_bad_r <= even_par_err(shift_r, rx_s);
    end
  end

  assign par_bad_s = par_bad_r;
`else
  assign par_bad_s = 1'b0;
`endif

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r       <= 8'h00;
      dout_vld_r   <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      if (good_s) dout_r <= shift_r;
      dout_vld_r   <= good_s;
      frame_err_r  <= ferr_s;
      parity_err_r <= perr_s;
      busy_r       <= (state_nx_s != IDLE);
    end
  end

  assign dout       = dout_r;
  assign dout_vld   = dout_vld_r;
  assign frame_err  = frame_err_r;
  assign parity_err = parity_err_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven bit by bit, pulses are
// logged with their cycle number and compared with times derived from the baud rules.
module tb_uart_rx;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 115_200;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int HALF     = BIT / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  // Pin change to start-edge detection: two sync flops plus the edge register.
  localparam int T0 = 3;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       dout_vld;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int   cyc = 0;
  int   asserts = 0;
  int   fails = 0;
  logic busy_prev = 1'b0;
  logic [7:0] last_good = 8'h00;

  ev_t vld_q[$];
  int  ferr_q[$];
  int  perr_q[$];
  int  brise_q[$];
  int  bfall_q[$];

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_vld) vld_q.push_back('{cyc, dout});
      if (frame_err) ferr_q.push_back(cyc);
      if (parity_err) perr_q.push_back(cyc);
      if (busy && !busy_prev) brise_q.push_back(cyc);
      if (!busy && busy_prev) bfall_q.push_back(cyc);
    end
    busy_prev <= busy;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    vld_q.delete();
    ferr_q.delete();
    perr_q.delete();
    brise_q.delete();
    bfall_q.delete();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic par_flip, output int start);
    start = cyc;
    rx = 1'b0;
    wait_cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    wait_cycles(BIT);
`endif
    rx = stop_bit;
    wait_cycles(BIT);
  endtask

  task automatic test_reset();
    wait_cycles(3);
    asserts++; if (dout !== 8'h00) begin fails++; $display("FAIL reset_dout: got %0h want 00", dout); end
    asserts++; if (dout_vld !== 1'b0) begin fails++; $display("FAIL reset_vld: got %b want 0", dout_vld); end
    asserts++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    asserts++; if (parity_err !== 1'b0) begin fails++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    wait_cycles(10);
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int st, d;
    clear_q();
    send_frame(8'h55, 1'b1, 1'b0, st);
    wait_cycles(20);
    asserts++; if (vld_q.size() != 1) begin fails++; $display("FAIL single_count: got %0d want 1", vld_q.size()); end
    asserts++; if (vld_q.size() < 1 || vld_q[0].data !== 8'h55) begin fails++; $display("FAIL single_data: got %0h want 55", dout); end
    d = (vld_q.size() > 0) ? vld_q[0].cyc - (st + T0 + HALF + NB * BIT) : 999;
    asserts++; if (d < -1 || d > 1) begin fails++; $display("FAIL single_time: offset %0d want within 1", d); end
    asserts++; if (ferr_q.size() != 0 || perr_q.size() != 0) begin fails++; $display("FAIL single_err: got %0d/%0d want 0/0", ferr_q.size(), perr_q.size()); end
    asserts++; if (dout !== 8'h55) begin fails++; $display("FAIL single_hold: got %0h want 55", dout); end
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy: got %b want 0", busy); end
    asserts++; if (brise_q.size() != 1 || brise_q[0] < st + T0 || brise_q[0] > st + T0 + 2) begin fails++; $display("FAIL busy_rise: got %0d events want 1 near %0d", brise_q.size(), st + T0 + 1); end
    asserts++; if (bfall_q.size() != 1 || vld_q.size() < 1 || bfall_q[0] != vld_q[0].cyc) begin fails++; $display("FAIL busy_fall: got %0d events want 1 with dout_vld", bfall_q.size()); end
    last_good = 8'h55;
  endtask

  task automatic test_back_to_back();
    int st1, st2, d;
    clear_q();
    send_frame(8'hA3, 1'b1, 1'b0, st1);
    send_frame(8'h0F, 1'b1, 1'b0, st2);
    wait_cycles(20);
    asserts++; if (vld_q.size() != 2) begin fails++; $display("FAIL b2b_count: got %0d want 2", vld_q.size()); end
    asserts++; if (vld_q.size() < 1 || vld_q[0].data !== 8'hA3) begin fails++; $display("FAIL b2b_data0: want a3"); end
    asserts++; if (vld_q.size() < 2 || vld_q[1].data !== 8'h0F) begin fails++; $display("FAIL b2b_data1: want 0f"); end
    d = (vld_q.size() > 1) ? vld_q[1].cyc - (st2 + T0 + HALF + NB * BIT) : 999;
    asserts++; if (d < -1 || d > 1) begin fails++; $display("FAIL b2b_time: offset %0d want within 1", d); end
    asserts++; if (ferr_q.size() != 0) begin fails++; $display("FAIL b2b_ferr: got %0d want 0", ferr_q.size()); end
    asserts++; if (brise_q.size() != 2 || bfall_q.size() != 2) begin fails++; $display("FAIL b2b_busy: got %0d rises %0d falls want 2/2", brise_q.size(), bfall_q.size()); end
    asserts++; if (brise_q.size() < 2 || bfall_q.size() < 1 || brise_q[1] - bfall_q[0] > HALF + 6) begin fails++; $display("FAIL b2b_gap: busy low too long between frames"); end
    last_good = 8'h0F;
  endtask

  task automatic test_glitch();
    int st;
    clear_q();
    st = cyc;
    rx = 1'b0;
    wait_cycles(100);
    rx = 1'b1;
    wait_cycles(121);
    @(negedge clk);
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy: got %b want 0 at cycle %0d", busy, cyc - st); end
    asserts++; if (brise_q.size() != 1) begin fails++; $display("FAIL glitch_start: got %0d busy rises want 1", brise_q.size()); end
    wait_cycles(300);
    asserts++; if (vld_q.size() != 0 || ferr_q.size() != 0 || perr_q.size() != 0) begin fails++; $display("FAIL glitch_pulse: got %0d/%0d/%0d want 0/0/0", vld_q.size(), ferr_q.size(), perr_q.size()); end
    asserts++; if (dout !== last_good) begin fails++; $display("FAIL glitch_dout: got %0h want %0h", dout, last_good); end
  endtask

  task automatic test_frame_error();
    int st, d;
    clear_q();
    send_frame(8'hFF, 1'b0, 1'b0, st);
    wait_cycles(BIT);
    asserts++; if (busy !== 1'b1) begin fails++; $display("FAIL break_busy: got %b want 1", busy); end
    wait_cycles(2 * BIT);
    rx = 1'b1;
    wait_cycles(2 * BIT);
    asserts++; if (ferr_q.size() != 1) begin fails++; $display("FAIL ferr_count: got %0d want 1", ferr_q.size()); end
    d = (ferr_q.size() > 0) ? ferr_q[0] - (st + T0 + HALF + NB * BIT) : 999;
    asserts++; if (d < -1 || d > 1) begin fails++; $display("FAIL ferr_time: offset %0d want within 1", d); end
    asserts++; if (vld_q.size() != 0 || perr_q.size() != 0) begin fails++; $display("FAIL ferr_other: got %0d vld %0d perr want 0", vld_q.size(), perr_q.size()); end
    asserts++; if (dout !== last_good) begin fails++; $display("FAIL ferr_dout: got %0h want %0h", dout, last_good); end
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL ferr_busy: got %b want 0", busy); end
    clear_q();
    send_frame(8'h3C, 1'b1, 1'b0, st);
    wait_cycles(20);
    asserts++; if (vld_q.size() != 1 || vld_q[0].data !== 8'h3C) begin fails++; $display("FAIL after_ferr: got %0d frames dout %0h want 1 frame 3c", vld_q.size(), dout); end
    last_good = 8'h3C;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    int st;
    b = 8'h81;
    clear_q();
    rx = 1'b0;
    wait_cycles(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_cycles(BIT);
    end
    rx = b[4];
    wait_cycles(BIT / 2);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    asserts++; if (dout !== 8'h00) begin fails++; $display("FAIL mid_rst_dout: got %0h want 00", dout); end
    asserts++; if (dout_vld !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin fails++; $display("FAIL mid_rst_pulse: got %b%b%b want 000", dout_vld, frame_err, parity_err); end
    last_good = 8'h00;
    wait_cycles(5);
    rst_n = 1'b1;
    wait_cycles(20);
    asserts++; if (busy !== 1'b0 || vld_q.size() != 0) begin fails++; $display("FAIL mid_rst_after: busy %b frames %0d want 0/0", busy, vld_q.size()); end
    send_frame(b, 1'b1, 1'b0, st);
    wait_cycles(20);
    asserts++; if (vld_q.size() != 1 || dout !== 8'h81) begin fails++; $display("FAIL mid_rst_clean: got %0d frames dout %0h want 1 frame 81", vld_q.size(), dout); end
    last_good = 8'h81;
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int st;
    clear_q();
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      wait_cycles($urandom_range(0, BIT));
      send_frame(b, 1'b1, 1'b0, st);
      exp_q.push_back(b);
    end
    wait_cycles(20);
    asserts++; if (vld_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_count: got %0d want %0d", vld_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      asserts++;
      if (k >= vld_q.size() || vld_q[k].data !== exp_q[k]) begin
        fails++; $display("FAIL rand_data[%0d]: got %0h want %0h", k, (k < vld_q.size()) ? vld_q[k].data : 8'hxx, exp_q[k]);
      end
    end
    asserts++; if (ferr_q.size() != 0 || perr_q.size() != 0) begin fails++; $display("FAIL rand_err: got %0d/%0d want 0/0", ferr_q.size(), perr_q.size()); end
    if (exp_q.size() > 0) last_good = exp_q[exp_q.size() - 1];
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int st, d;
    clear_q();
    send_frame(8'h07, 1'b1, 1'b1, st);
    wait_cycles(20);
    asserts++; if (perr_q.size() != 1 || vld_q.size() != 0) begin fails++; $display("FAIL par_bad: got %0d perr %0d vld want 1/0", perr_q.size(), vld_q.size()); end
    d = (perr_q.size() > 0) ? perr_q[0] - (st + T0 + HALF + NB * BIT) : 999;
    asserts++; if (d < -1 || d > 1) begin fails++; $display("FAIL par_time: offset %0d want within 1", d); end
    asserts++; if (dout !== last_good) begin fails++; $display("FAIL par_hold: got %0h want %0h", dout, last_good); end
    clear_q();
    send_frame(8'h07, 1'b1, 1'b0, st);
    wait_cycles(20);
    asserts++; if (vld_q.size() != 1 || dout !== 8'h07 || perr_q.size() != 0) begin fails++; $display("FAIL par_good: got %0d vld dout %0h want 1 vld 07", vld_q.size(), dout); end
    last_good = 8'h07;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
